// File: rtl/keypad_pkg.sv
// Shared types and the key map for the matrix keypad scanner.
// KEY_MAP is indexed {row,col}; classify_hits reduces a 16-position hit map to one scan result.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } kp_state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } scan_kind_e;

  typedef struct packed {
    scan_kind_e kind;
    logic [3:0] code;
  } scan_result_t;

  localparam logic [3:0] KEY_MAP [0:15] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  function automatic scan_result_t classify_hits(input logic [15:0] hits);
    scan_result_t res;
    logic [4:0]   n;
    res.kind = NONE;
    res.code = 4'h0;
    n        = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, hits[i]};
      if (hits[i]) begin
        res.code = KEY_MAP[i];
      end else begin
        res.code = res.code;
      end
    end
    if (n == 5'd1) begin
      res.kind = SINGLE;
    end else if (n > 5'd1) begin
      res.kind = MULTI;
    end else begin
      res.kind = NONE;
    end
    return res;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key event bus from the keypad scanner to the digit-capture stage.
interface keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (output key_code, key_valid, key_down);
  modport slave  (input  key_code, key_valid, key_down);
endinterface

// File: rtl/kp_sync2.sv
// Four-bit two-flop synchroniser for asynchronous Pmod inputs.
// RST_VAL lets each user clear to its inputs' idle level.
module kp_sync2 #(
  parameter logic [3:0] RST_VAL = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_r;
  logic [3:0] sync_r;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks the columns, collects a full-scan hit map and debounces
// whole-scan results into a single key_valid strobe per confirmed press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  keypad_scanner_if.master kp
);

  localparam int DW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_SCANS - 1);

  logic [3:0]       row_sync_s;
  logic [3:0]       row_hit_s;
  logic [DW-1:0]    dwell_r;
  logic [1:0]       col_idx_r;
  logic [3:0]       col_r;
  logic [2:0][3:0]  hits_r;
  logic             last_dwell_s;
  logic             scan_end_s;
  logic [15:0]      all_hits_s;
  scan_result_t     scan_s;
  scan_result_t     res_r;
  logic             eval_r;
  kp_state_e        state_r;
  kp_state_e        state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
  logic [3:0]       cand_r;
  logic [3:0]       cand_nxt_s;
  logic             strobe_s;
  logic             down_clr_s;
  logic [3:0]       key_code_r;
  logic             key_valid_r;
  logic             key_down_r;

  kp_sync2 #(.RST_VAL(4'hF)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row),
    .q     (row_sync_s)
  );

  assign row_hit_s    = ~row_sync_s;
  assign last_dwell_s = (dwell_r == DWELL_LAST);
  assign scan_end_s   = last_dwell_s && (col_idx_r == 2'd3);

  // column dwell counter, column walk and per-column hit capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell_r   <= '0;
      col_idx_r <= 2'd0;
      col_r     <= 4'b1110;
      hits_r    <= '0;
    end else if (last_dwell_s) begin
      dwell_r   <= '0;
      col_idx_r <= col_idx_r + 2'd1;
      col_r     <= {col_r[2:0], col_r[3]};
      case (col_idx_r)
        2'd0:    hits_r[0] <= row_hit_s;
        2'd1:    hits_r[1] <= row_hit_s;
        2'd2:    hits_r[2] <= row_hit_s;
        default: hits_r    <= hits_r;
      endcase
    end else begin
      dwell_r <= dwell_r + DW'(1);
    end
  end

  // column 3 is taken live so the result is ready on its sample cycle
  always_comb begin
    all_hits_s = 16'h0000;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        all_hits_s[r*4+c] = hits_r[c][r];
      end
      all_hits_s[r*4+3] = row_hit_s[r];
    end
  end

  assign scan_s = classify_hits(all_hits_s);

  // registered scan result and its evaluation pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eval_r <= 1'b0;
      res_r  <= '{kind: NONE, code: 4'h0};
    end else begin
      eval_r <= scan_end_s;
      res_r  <= scan_end_s ? scan_s : res_r;
    end
  end

  // FSM state, debounce counter and candidate register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      cand_r  <= 4'h0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      cand_r  <= cand_nxt_s;
    end
  end

  // FSM next state; moves only on an evaluation pulse
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    cand_nxt_s  = cand_r;
    if (eval_r) begin
      case (state_r)
        IDLE: begin
          if (res_r.kind == SINGLE) begin
            cand_nxt_s  = res_r.code;
            cnt_nxt_s   = CW'(1);
            state_nxt_s = CONFIRM;
          end else begin
            cnt_nxt_s   = '0;
          end
        end
        CONFIRM: begin
          if ((res_r.kind == SINGLE) && (res_r.code == cand_r)) begin
            if (cnt_r == CNT_LAST) begin
              cnt_nxt_s   = '0;
              state_nxt_s = HELD;
            end else begin
              cnt_nxt_s   = cnt_r + CW'(1);
            end
          end else begin
            cnt_nxt_s   = '0;
            state_nxt_s = IDLE;
          end
        end
        HELD: begin
          if (res_r.kind == NONE) begin
            cnt_nxt_s   = CW'(1);
            state_nxt_s = RELEASE;
          end else begin
            state_nxt_s = HELD;
          end
        end
        RELEASE: begin
          if (res_r.kind == NONE) begin
            if (cnt_r == CNT_LAST) begin
              cnt_nxt_s   = '0;
              state_nxt_s = IDLE;
            end else begin
              cnt_nxt_s   = cnt_r + CW'(1);
            end
          end else begin
            cnt_nxt_s   = '0;
            state_nxt_s = HELD;
          end
        end
        default: begin
          cnt_nxt_s   = '0;
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM outputs: accept and release-complete events
  always_comb begin
    strobe_s   = 1'b0;
    down_clr_s = 1'b0;
    case (state_r)
      CONFIRM: strobe_s   = eval_r && (state_nxt_s == HELD);
      RELEASE: down_clr_s = eval_r && (state_nxt_s == IDLE);
      default: begin
        strobe_s   = 1'b0;
        down_clr_s = 1'b0;
      end
    endcase
  end

  // registered key event outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_code_r  <= 4'h0;
      key_valid_r <= 1'b0;
      key_down_r  <= 1'b0;
    end else begin
      key_valid_r <= strobe_s;
      key_code_r  <= strobe_s ? cand_r : key_code_r;
      if (strobe_s) begin
        key_down_r <= 1'b1;
      end else if (down_clr_s) begin
        key_down_r <= 1'b0;
      end else begin
        key_down_r <= key_down_r;
      end
    end
  end

  assign col          = col_r;
  assign kp.key_code  = key_code_r;
  assign kp.key_valid = key_valid_r;
  assign kp.key_down  = key_down_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a scan-level vector table driving a keypad model,
// plus a hand-written reset-during-confirm sequence with an exact latency check.
module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] pressed;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  int          checks;
  int          failures;

  keypad_scanner_if kp_if ();

  keypad_scanner #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .row   (row),
    .col   (col),
    .kp    (kp_if)
  );

  assign key_code  = kp_if.key_code;
  assign key_valid = kp_if.key_valid;
  assign key_down  = kp_if.key_down;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // keypad model: pressed key (r,c) pulls row r low while column c is driven low
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  typedef struct {
    logic [15:0] keys;
    logic        exp_valid;
    logic [3:0]  exp_code;
    logic        exp_down;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [15:0] k, input logic v, input logic [3:0] c, input logic d);
    vec_t e;
    e.keys = k; e.exp_valid = v; e.exp_code = c; e.exp_down = d;
    tbl.push_back(e);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // one full scan (16 cycles) starting at the negedge of its cycle 0
  task automatic run_scan(input int s, input logic [15:0] keys, input logic exp_v,
                          input logic [3:0] exp_c, input logic exp_d);
    int         nstrobe;
    int         pos;
    logic [3:0] scode;
    logic [3:0] exp_col;
    pressed = keys;
    nstrobe = 0;
    pos     = -1;
    scode   = 4'h0;
    for (int i = 0; i < 16; i++) begin
      exp_col = ~(4'b0001 << (i / 4));
      check("col", s*16+i, {28'd0, col}, {28'd0, exp_col});
      if (key_valid) begin
        nstrobe++;
        pos   = i;
        scode = key_code;
      end
      @(negedge clk);
    end
    check("strobe_count", s, nstrobe, {31'd0, exp_v});
    if (exp_v) begin
      check("strobe_pos", s, pos, 32'd1);
      check("strobe_code", s, {28'd0, scode}, {28'd0, exp_c});
    end
    check("key_code", s, {28'd0, key_code}, {28'd0, exp_c});
    check("key_down", s, {31'd0, key_down}, {31'd0, exp_d});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_col", 0, {28'd0, col}, 32'h0000_000E);
    check("rst_code", 0, {28'd0, key_code}, 32'd0);
    check("rst_valid", 0, {31'd0, key_valid}, 32'd0);
    check("rst_down", 0, {31'd0, key_down}, 32'd0);
    rst_n = 1'b1;
  endtask

  localparam logic [15:0] K1 = 16'h0001;
  localparam logic [15:0] K3 = 16'h0004;
  localparam logic [15:0] KA = 16'h0008;
  localparam logic [15:0] K5 = 16'h0020;
  localparam logic [15:0] K6 = 16'h0040;
  localparam logic [15:0] K9 = 16'h0400;
  localparam logic [15:0] KD = 16'h8000;
  localparam logic [15:0] KN = 16'h0000;

  initial begin
    int cyc;
    int extra;
    checks   = 0;
    failures = 0;
    pressed  = KN;
    rst_n    = 1'b0;

    // idle after reset
    add(KN, 1'b0, 4'h0, 1'b0); add(KN, 1'b0, 4'h0, 1'b0);
    // clean press of 6 for six scans, then release
    for (int i = 0; i < 3; i++) add(K6, 1'b0, 4'h0, 1'b0);
    add(K6, 1'b1, 4'h6, 1'b1); add(K6, 1'b0, 4'h6, 1'b1); add(K6, 1'b0, 4'h6, 1'b1);
    for (int i = 0; i < 3; i++) add(KN, 1'b0, 4'h6, 1'b1);
    add(KN, 1'b0, 4'h6, 1'b0);
    // glitchy 9
    add(K9, 1'b0, 4'h6, 1'b0); add(KN, 1'b0, 4'h6, 1'b0);
    add(K9, 1'b0, 4'h6, 1'b0); add(KN, 1'b0, 4'h6, 1'b0);
    for (int i = 0; i < 3; i++) add(K9, 1'b0, 4'h6, 1'b0);
    add(KN, 1'b1, 4'h9, 1'b1); add(KN, 1'b0, 4'h9, 1'b1); add(KN, 1'b0, 4'h9, 1'b1);
    add(KN, 1'b0, 4'h9, 1'b0);
    // 1+5 together, then 1 alone
    add(K1 | K5, 1'b0, 4'h9, 1'b0); add(K1 | K5, 1'b0, 4'h9, 1'b0);
    for (int i = 0; i < 3; i++) add(K1, 1'b0, 4'h9, 1'b0);
    add(KN, 1'b1, 4'h1, 1'b1); add(KN, 1'b0, 4'h1, 1'b1); add(KN, 1'b0, 4'h1, 1'b1);
    add(KN, 1'b0, 4'h1, 1'b0);
    // D held, A added while held
    for (int i = 0; i < 3; i++) add(KD, 1'b0, 4'h1, 1'b0);
    add(KD | KA, 1'b1, 4'hD, 1'b1); add(KD | KA, 1'b0, 4'hD, 1'b1);
    for (int i = 0; i < 3; i++) add(KN, 1'b0, 4'hD, 1'b1);
    add(KN, 1'b0, 4'hD, 1'b0);
    // first matching scan of 3
    add(K3, 1'b0, 4'hD, 1'b0);

    do_reset();
    for (int s = 0; s < tbl.size(); s++) begin
      run_scan(s, tbl[s].keys, tbl[s].exp_valid, tbl[s].exp_code, tbl[s].exp_down);
    end

    // reset in the middle of the second matching scan of 3
    repeat (8) begin
      check("no_strobe_pre_rst", 0, {31'd0, key_valid}, 32'd0);
      @(negedge clk);
    end
    do_reset();

    cyc = 0;
    while (!key_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_repress_latency", 0, cyc, 32'd49);
    check("rst_repress_code", 0, {28'd0, key_code}, 32'h0000_0003);
    extra = 0;
    @(negedge clk);
    check("rst_repress_down", 0, {31'd0, key_down}, 32'd1);
    pressed = KN;
    repeat (80) begin
      if (key_valid) extra++;
      @(negedge clk);
    end
    check("rst_repress_single", 0, extra, 32'd0);
    check("rst_release_down", 0, {31'd0, key_down}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
